// File: rtl/fifo_pkg.sv
// Shared defaults and FSM state encoding for the FIFO word packer.
package fifo_pkg;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int LANES_DEF      = 4;

    typedef enum logic [1:0] {
        S_REQ = 2'd0,
        S_CAP = 2'd1,
        S_OUT = 2'd2
    } pack_state_e;
endpackage

// File: rtl/fifo_word_packer_if.sv
// Packer bus: FIFO read side (rd_en/data_out/empty), flush request and the packed-word valid/ready output.
interface fifo_word_packer_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int LANES      = LANES_DEF
) ();
    logic                        fifo_empty;
    logic [DATA_WIDTH-1:0]       fifo_data_out;
    logic                        fifo_rd_en;
    logic                        flush;
    logic [DATA_WIDTH*LANES-1:0] word_data;
    logic [LANES-1:0]            word_keep;
    logic                        word_valid;
    logic                        word_ready;

    modport master (
        input  fifo_empty, fifo_data_out, flush, word_ready,
        output fifo_rd_en, word_data, word_keep, word_valid
    );

    modport slave (
        output fifo_empty, fifo_data_out, flush, word_ready,
        input  fifo_rd_en, word_data, word_keep, word_valid
    );
endinterface

// File: rtl/fifo.sv
// Generic synchronous FIFO; data_out is registered one cycle after an accepted read, empty/full are registered.
// Writes when full and reads when empty are ignored.
module fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [DW-1:0] data_in,
    input  logic          rd_en,
    output logic [DW-1:0] data_out,
    output logic          empty,
    output logic          full
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic [DW-1:0] data_out_q;
    logic          empty_q, full_q;
    logic          do_wr, do_rd;

    assign do_wr    = wr_en && !full_q;
    assign do_rd    = rd_en && !empty_q;
    assign cnt_d    = cnt_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    assign data_out = data_out_q;
    assign empty    = empty_q;
    assign full     = full_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            data_out_q <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
        end else begin
            if (do_wr) wptr_q <= wptr_q + AW'(1);
            if (do_rd) begin
                rptr_q     <= rptr_q + AW'(1);
                data_out_q <= mem_q[rptr_q];
            end
            cnt_q   <= cnt_d;
            empty_q <= (cnt_d == '0);
            full_q  <= (cnt_d == (AW+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wptr_q] <= data_in;
    end
endmodule

// File: rtl/fifo_word_packer.sv
// Packs LANES FIFO entries into one word (first word valid 2*LANES cycles after the first read, lane 0 in the LSBs).
// Holds the word until word_ready with no reads meanwhile; flush emits a partial word once the FIFO runs empty.
module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int LANES      = LANES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    fifo_word_packer_if.master pk_if
);
    localparam int            CW   = $clog2(LANES + 1);
    localparam logic [CW-1:0] LAST = CW'(LANES - 1);

    pack_state_e                      state_q;
    logic [CW-1:0]                    count_q, count_d;
    logic [LANES-1:0][DATA_WIDTH-1:0] lanes_q;
    logic [LANES-1:0]                 keep_q;
    logic [LANES-1:0]                 flush_keep;
    logic                             valid_q;

    assign count_d    = count_q + CW'(1);
    assign flush_keep = (LANES'(1) << count_q) - LANES'(1);

    // Reads only from S_REQ, so every strobe is followed by at least one idle cycle.
    assign pk_if.fifo_rd_en = (state_q == S_REQ) && !pk_if.fifo_empty && !reset;
    assign pk_if.word_data  = lanes_q;
    assign pk_if.word_keep  = keep_q;
    assign pk_if.word_valid = valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_REQ;
            count_q <= '0;
            lanes_q <= '0;
            keep_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (!pk_if.fifo_empty) begin
                        state_q <= S_CAP;
                    end else if (pk_if.flush && (count_q != '0)) begin
                        state_q <= S_OUT;
                        keep_q  <= flush_keep;
                        valid_q <= 1'b1;
                    end
                end
                S_CAP: begin
                    for (int i = 0; i < LANES; i++) begin
                        if (count_q == CW'(i)) lanes_q[i] <= pk_if.fifo_data_out;
                    end
                    count_q <= count_d;
                    if (count_q == LAST) begin
                        state_q <= S_OUT;
                        keep_q  <= '1;
                        valid_q <= 1'b1;
                    end else begin
                        state_q <= S_REQ;
                    end
                end
                S_OUT: begin
                    // Clearing lanes here keeps unfilled lanes of a later partial word at zero.
                    if (pk_if.word_ready) begin
                        state_q <= S_REQ;
                        count_q <= '0;
                        lanes_q <= '0;
                        keep_q  <= '0;
                        valid_q <= 1'b0;
                    end
                end
                default: state_q <= S_REQ;
            endcase
        end
    end
endmodule
